addsub_4bit_bist: RTL

//  Hardware self-test driver/checker for addsub_4bit: the stimulus-and-compare end of its interface.

---
 rtl/alu_test_pkg.sv | 26 ++
 rtl/lfsr8.sv | 21 ++
 rtl/addsub_4bit_bist.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/alu_test_pkg.sv
// Shared types and golden model for the addsub_4bit self-test.
// exp_addsub4 is also reused by the software-level benches.
package alu_test_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        SUB  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Returns {ovfl, sum}; sum wraps mod 16, ovfl is signed overflow.
    function automatic logic [4:0] exp_addsub4(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic       sub);
        logic [3:0] s;
        logic       ovfl;
        s    = sub ? (a - b) : (a + b);
        ovfl = sub ? ((a[3] != b[3]) && (s[3] != a[3]))
                   : ((a[3] == b[3]) && (s[3] != a[3]));
        return {ovfl, s};
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Galois LFSR, right shift; reset and load both restore the seed.
module lfsr8
    import alu_test_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       step,
    output logic [7:0] q
);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            q <= seed;
        end else if (step) begin
            q <= {1'b0, q[7:1]} ^ (q[0] ? LFSR_TAPS : 8'h00);
        end
    end

endmodule

// File: rtl/addsub_4bit_bist.sv
// Stimulus/compare engine for addsub_4bit: ADD phase then SUB phase,
// reporting pass/fail, a saturating mismatch count and the first failing vector.
//
//  state | meaning
//  ------+--------------------------------------------------------------
//  IDLE  | after reset, waiting for start
//  ADD   | sub=0, one vector per cycle, compared at the edge ending it
//  SUB   | sub=1, same vector sequence reloaded from SEED
//  DONE  | results held; start launches a fresh run
module addsub_4bit_bist
    import alu_test_pkg::*;
#(
    parameter int         NUM_VEC      = 100,
    parameter logic [7:0] SEED         = 8'hA5,
    parameter bit         STOP_ON_FAIL = 1'b1,
    parameter int         CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [3:0]       A,
    output logic [3:0]       B,
    output logic             sub,
    input  logic [3:0]       Sum,
    input  logic             Ovfl,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [13:0]      fail_info
);

    localparam int            VW       = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
    localparam logic [VW-1:0] VEC_LAST = VW'(NUM_VEC - 1);

    state_t             state, state_nxt;
    logic [VW-1:0]      vec_left, vec_left_nxt;
    logic [3:0]         a_nxt, b_nxt;
    logic               sub_nxt, busy_nxt, done_nxt, pass_nxt;
    logic [CNT_W-1:0]   err_nxt, err_new, err_inc;
    logic [13:0]        fi_nxt;
    logic               lfsr_load, lfsr_step;
    logic [7:0]         lfsr_q;
    logic [4:0]         golden;
    logic               mismatch;

    lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .seed (SEED),
        .step (lfsr_step),
        .q    (lfsr_q)
    );

    assign golden   = exp_addsub4(A, B, sub);
    // Sum is meaningless once overflow is expected, so only Ovfl is judged then.
    assign mismatch = (Ovfl != golden[4]) || (!golden[4] && (Sum != golden[3:0]));
    assign err_inc  = (&err_cnt) ? err_cnt : err_cnt + CNT_W'(1);
    assign err_new  = mismatch ? err_inc : err_cnt;

    always_comb begin
        state_nxt    = state;
        vec_left_nxt = vec_left;
        a_nxt        = A;
        b_nxt        = B;
        sub_nxt      = sub;
        busy_nxt     = busy;
        done_nxt     = done;
        pass_nxt     = pass;
        err_nxt      = err_cnt;
        fi_nxt       = fail_info;
        lfsr_load    = 1'b0;
        lfsr_step    = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt    = ADD;
                    vec_left_nxt = VEC_LAST;
                    a_nxt        = 4'h0;
                    b_nxt        = 4'h0;
                    sub_nxt      = 1'b0;
                    busy_nxt     = 1'b1;
                    done_nxt     = 1'b0;
                    pass_nxt     = 1'b0;
                    err_nxt      = '0;
                    fi_nxt       = '0;
                    lfsr_load    = 1'b1;
                end
            end

            ADD, SUB: begin
                err_nxt = err_new;
                if (mismatch && (err_cnt == '0)) begin
                    fi_nxt = {sub, A, B, Sum, Ovfl};
                end

                if (mismatch && STOP_ON_FAIL) begin
                    // Operands stay on the failing vector for inspection.
                    state_nxt = DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    pass_nxt  = 1'b0;
                end else if (vec_left == '0) begin
                    if (state == ADD) begin
                        state_nxt    = SUB;
                        vec_left_nxt = VEC_LAST;
                        a_nxt        = 4'h0;
                        b_nxt        = 4'h0;
                        sub_nxt      = 1'b1;
                        lfsr_load    = 1'b1;
                    end else begin
                        state_nxt = DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        pass_nxt  = (err_new == '0);
                    end
                end else begin
                    vec_left_nxt = vec_left - VW'(1);
                    a_nxt        = lfsr_q[7:4];
                    b_nxt        = lfsr_q[3:0];
                    lfsr_step    = 1'b1;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            vec_left  <= '0;
            A         <= 4'h0;
            B         <= 4'h0;
            sub       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            fail_info <= '0;
        end else begin
            state     <= state_nxt;
            vec_left  <= vec_left_nxt;
            A         <= a_nxt;
            B         <= b_nxt;
            sub       <= sub_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            pass      <= pass_nxt;
            err_cnt   <= err_nxt;
            fail_info <= fi_nxt;
        end
    end

endmodule
